// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// acc_pkg : shared state, opcode-class and ALU definitions for acc_core_p
// Rev 1.0
// ============================================================================
package acc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADC = 2'd0,
    ALU_SBC = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  localparam int c_flag_cf = 0;
  localparam int c_flag_zf = 1;
  localparam int c_flag_nf = 2;
  localparam int c_flag_vf = 3;

  localparam logic [7:0] c_op_halt = 8'h01;
  localparam logic [7:0] c_op_clc  = 8'h04;
  localparam logic [7:0] c_op_sec  = 8'h05;

  // An opcode belongs to a class when (op & mask) == match
  localparam logic [7:0] c_mask_alu   = 8'hF8, c_match_alu   = 8'h08;
  localparam logic [7:0] c_mask_mov   = 8'hFC, c_match_mov   = 8'h10;
  localparam logic [7:0] c_mask_st    = 8'hFC, c_match_st    = 8'h14;
  localparam logic [7:0] c_mask_skip  = 8'hF8, c_match_skip  = 8'h18;
  localparam logic [7:0] c_mask_ldx   = 8'hE0, c_match_ldx   = 8'h20;
  localparam logic [7:0] c_mask_jmp   = 8'hE0, c_match_jmp   = 8'h60;
  localparam logic [7:0] c_mask_imm   = 8'hC0, c_match_imm   = 8'h80;
  localparam logic [7:0] c_mask_rsv_a = 8'hFE, c_match_rsv_a = 8'h02;
  localparam logic [7:0] c_mask_rsv_b = 8'hE0, c_match_rsv_b = 8'h40;
  localparam logic [7:0] c_mask_rsv_c = 8'hC0, c_match_rsv_c = 8'hC0;

  function automatic logic op_is(input logic [7:0] op, input logic [7:0] mask,
                                 input logic [7:0] match);
    return (op & mask) == match;
  endfunction

  function automatic logic op_reads_mem(input logic [7:0] op);
    return (op_is(op, c_mask_alu, c_match_alu) && op[0]) ||
           (op_is(op, c_mask_mov, c_match_mov) && op[1]);
  endfunction

  function automatic logic op_writes_mem(input logic [7:0] op);
    return op_is(op, c_mask_st, c_match_st);
  endfunction

  function automatic logic op_reserved(input logic [7:0] op);
    return op_is(op, c_mask_rsv_a, c_match_rsv_a) ||
           op_is(op, c_mask_rsv_b, c_match_rsv_b) ||
           op_is(op, c_mask_rsv_c, c_match_rsv_c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_core_p_if.sv
`default_nettype none
// ============================================================================
// acc_core_p_if : shared instruction/data bus with ready handshake
// Rev 1.0
// ============================================================================
interface acc_core_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W:0]   mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/acc_alu_p.sv
`default_nettype none
// ============================================================================
// acc_alu_p : combinational ADC/SBC/AND/XOR with carry, zero, sign, overflow
// Rev 1.0
// ============================================================================
module acc_alu_p
  import acc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              ci,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z,
  output logic              n,
  output logic              v
);

  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_sum;

  always_comb begin
    // SBC is AX + ~B + CF, so carry set means no borrow
    w_b_eff = (op == ALU_SBC) ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, ci};
    y       = w_sum[DATA_W-1:0];
    c       = w_sum[DATA_W];
    v       = (a[DATA_W-1] == w_b_eff[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
    case (op)
      ALU_AND: begin
        y = a & b;
        c = ci;
        v = 1'b0;
      end
      ALU_XOR: begin
        y = a ^ b;
        c = ci;
        v = 1'b0;
      end
      default: ;
    endcase
    z = (y == '0);
    n = y[DATA_W-1];
  end

endmodule
`default_nettype wire

// File: rtl/acc_core_p.sv
`default_nettype none
// ============================================================================
// acc_core_p : multi-cycle accumulator core on a shared ready-handshake bus
// Rev 1.0
// ============================================================================
module acc_core_p
  import acc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int IX_W   = 5
) (
  input  logic         clk,
  input  logic         reset,
  acc_core_p_if.master bus,
  output logic         halted,
  output logic         illegal
);

  state_e            r_state;
  logic [DATA_W-1:0] r_ax, r_dx, r_m, r_wdata;
  logic [ADDR_W-1:0] r_ip;
  logic [IX_W-1:0]   r_ix;
  logic [7:0]        r_ir;
  logic              r_cf, r_zf, r_nf, r_vf;
  logic [ADDR_W:0]   r_addr;
  logic              r_rd, r_wr, r_halted, r_illegal;

  logic [7:0]        w_fop;
  logic [ADDR_W:0]   w_data_addr;
  logic [DATA_W-1:0] w_alu_b, w_alu_y, w_tgt, w_imm_val;
  logic              w_alu_c, w_alu_z, w_alu_n, w_alu_v;
  logic [3:0]        w_flags;
  logic [ADDR_W-1:0] w_ip_next;

  assign w_fop       = bus.mem_rdata[7:0];
  assign w_data_addr = {1'b1, ADDR_W'(r_ix)};
  assign w_alu_b     = r_ir[0] ? r_m : r_dx;

  acc_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op_e'(r_ir[2:1])),
    .a  (r_ax),
    .b  (w_alu_b),
    .ci (r_cf),
    .y  (w_alu_y),
    .c  (w_alu_c),
    .z  (w_alu_z),
    .n  (w_alu_n),
    .v  (w_alu_v)
  );

  always_comb begin
    w_flags            = '0;
    w_flags[c_flag_cf] = r_cf;
    w_flags[c_flag_zf] = r_zf;
    w_flags[c_flag_nf] = r_nf;
    w_flags[c_flag_vf] = r_vf;

    w_tgt     = r_ir[0] ? r_dx : r_ax;
    w_imm_val = r_ir[5] ? {w_tgt[DATA_W-5:0], r_ir[4:1]} : DATA_W'(r_ir[4:1]);

    // Jumps are relative to the jump's own address; IP wraps silently
    w_ip_next = r_ip + ADDR_W'(1);
    if (op_is(r_ir, c_mask_skip, c_match_skip) && (w_flags[r_ir[2:1]] != r_ir[0]))
      w_ip_next = r_ip + ADDR_W'(2);
    else if (op_is(r_ir, c_mask_jmp, c_match_jmp))
      w_ip_next = r_ip + ADDR_W'($signed(r_ir[4:0]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_ax      <= '0;
      r_dx      <= '0;
      r_m       <= '0;
      r_ix      <= '0;
      r_ip      <= '0;
      r_ir      <= '0;
      r_cf      <= 1'b0;
      r_zf      <= 1'b0;
      r_nf      <= 1'b0;
      r_vf      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b1;
      r_wr      <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            r_ir <= w_fop;
            if (op_reads_mem(w_fop)) begin
              r_state <= ST_LOAD;
              r_addr  <= w_data_addr;
            end else if (op_writes_mem(w_fop)) begin
              r_state <= ST_STORE;
              r_rd    <= 1'b0;
              r_wr    <= 1'b1;
              r_addr  <= w_data_addr;
              r_wdata <= w_fop[0] ? r_dx : r_ax;
            end else begin
              r_state   <= ST_EXEC;
              r_rd      <= 1'b0;
              r_illegal <= op_reserved(w_fop);
            end
          end
        end

        ST_LOAD: begin
          if (bus.mem_ready) begin
            r_m     <= bus.mem_rdata;
            r_rd    <= 1'b0;
            r_state <= ST_EXEC;
          end
        end

        ST_STORE: begin
          if (bus.mem_ready) begin
            r_wr    <= 1'b0;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_ip <= w_ip_next;
          if (r_ir == c_op_clc) begin
            r_cf <= 1'b0;
          end else if (r_ir == c_op_sec) begin
            r_cf <= 1'b1;
          end else if (op_is(r_ir, c_mask_alu, c_match_alu)) begin
            r_ax <= w_alu_y;
            r_cf <= w_alu_c;
            r_zf <= w_alu_z;
            r_nf <= w_alu_n;
            r_vf <= w_alu_v;
          end else if (op_is(r_ir, c_mask_mov, c_match_mov)) begin
            if (r_ir[0]) r_dx <= r_ir[1] ? r_m : r_ax;
            else         r_ax <= r_ir[1] ? r_m : r_dx;
          end else if (op_is(r_ir, c_mask_ldx, c_match_ldx)) begin
            r_ix <= IX_W'(r_ir[4:0]);
          end else if (op_is(r_ir, c_mask_imm, c_match_imm)) begin
            if (r_ir[0]) r_dx <= w_imm_val;
            else         r_ax <= w_imm_val;
          end

          if (r_ir == c_op_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_FETCH;
            r_rd    <= 1'b1;
            r_addr  <= {1'b0, w_ip_next};
          end
        end

        ST_HALT: ;

        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_rd    = r_rd;
  assign bus.mem_wr    = r_wr;
  assign bus.mem_wdata = r_wdata;
  assign halted        = r_halted;
  assign illegal       = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_acc_core_p.sv
`default_nettype none
// ============================================================================
// tb_acc_core_p : directed and random instruction streams against an ISA model
// Rev 1.0
// ============================================================================
module tb_acc_core_p;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int IXW = 5;
  localparam int MOD = 1 << DW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic halted, illegal;

  always #5 clk = ~clk;

  acc_core_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  acc_core_p #(.DATA_W(DW), .ADDR_W(AW), .IX_W(IXW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .halted  (halted),
    .illegal (illegal)
  );

  int errors = 0;
  int checks = 0;
  int m_ax, m_dx, m_ix, m_ip, m_cf, m_zf, m_nf, m_vf;
  int dmem [32];
  int last_wr_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= MOD / 2) ? x - MOD : x;
  endfunction

  function automatic bit is_load(input logic [7:0] op);
    casez (op)
      8'b00001??1, 8'b0001001?: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic bit is_store(input logic [7:0] op);
    casez (op)
      8'b000101??: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic bit is_rsv(input logic [7:0] op);
    casez (op)
      8'h02, 8'h03, 8'b010?????, 8'b11??????: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_ax = 0; m_dx = 0; m_ix = 0; m_ip = 0;
    m_cf = 0; m_zf = 0; m_nf = 0; m_vf = 0;
  endtask

  // Architectural effect of one instruction, from the ISA rules
  task automatic model_exec(input logic [7:0] op, input int mval);
    int b, sum, res, sv, off, t, cin, flag, nip;
    nip = (m_ip + 1) % 256;
    casez (op)
      8'h04: m_cf = 0;
      8'h05: m_cf = 1;
      8'b00001???: begin
        b   = op[0] ? mval : m_dx;
        cin = m_cf;
        res = 0;
        case (op[2:1])
          2'd0: begin
            sum = m_ax + b + cin; res = sum % MOD; m_cf = sum / MOD;
            sv = sx(m_ax) + sx(b) + cin;
            m_vf = (sv >= MOD / 2 || sv < -(MOD / 2)) ? 1 : 0;
          end
          2'd1: begin
            sum = m_ax + (MOD - 1 - b) + cin; res = sum % MOD; m_cf = sum / MOD;
            sv = sx(m_ax) - sx(b) - 1 + cin;
            m_vf = (sv >= MOD / 2 || sv < -(MOD / 2)) ? 1 : 0;
          end
          2'd2: begin res = m_ax & b; m_vf = 0; end
          default: begin res = m_ax ^ b; m_vf = 0; end
        endcase
        m_ax = res;
        m_zf = (res == 0) ? 1 : 0;
        m_nf = (res >= MOD / 2) ? 1 : 0;
      end
      8'b000100?0: m_ax = op[1] ? mval : m_dx;
      8'b000100?1: m_dx = op[1] ? mval : m_ax;
      8'b00011???: begin
        case (op[2:1])
          2'd0: flag = m_cf;
          2'd1: flag = m_zf;
          2'd2: flag = m_nf;
          default: flag = m_vf;
        endcase
        if (flag != int'(op[0])) nip = (m_ip + 2) % 256;
      end
      8'b001?????: m_ix = int'(op[4:0]) % (1 << IXW);
      8'b011?????: begin
        off = int'(op[4:0]);
        if (off >= 16) off = off - 32;
        nip = (m_ip + off + 256) % 256;
      end
      8'b10??????: begin
        t = op[0] ? m_dx : m_ax;
        t = op[5] ? (t * 16 + int'(op[4:1])) % MOD : int'(op[4:1]);
        if (op[0]) m_dx = t; else m_ax = t;
      end
      default: ;
    endcase
    m_ip = nip;
  endtask

  task automatic check_state(input bit skip_ip);
    chk("ax", dut.r_ax, m_ax);
    chk("dx", dut.r_dx, m_dx);
    chk("ix", dut.r_ix, m_ix);
    if (!skip_ip) chk("ip", dut.r_ip, m_ip);
    chk("flags", {dut.r_cf, dut.r_zf, dut.r_nf, dut.r_vf},
        {m_cf[0], m_zf[0], m_nf[0], m_vf[0]});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Entered at a negedge with the core in FETCH; leaves at the negedge after EXEC
  task automatic exec_one(input logic [7:0] op, input int fw, input int dw);
    logic [AW:0] fa, da;
    int mval;
    bit ld, st, hlt;
    fa  = {1'b0, AW'(m_ip)};
    da  = {1'b1, AW'(m_ix)};
    ld  = is_load(op);
    st  = is_store(op);
    hlt = (op == 8'h01);
    mval = 0;
    last_wr_cycles = 0;
    bus_if.mem_ready = 1'b0;
    chk("fetch_req", {bus_if.mem_rd, bus_if.mem_wr}, 2'b10);
    chk("fetch_addr", bus_if.mem_addr, fa);
    for (int i = 0; i < fw; i++) begin
      @(negedge clk);
      chk("fetch_hold", {bus_if.mem_rd, bus_if.mem_wr, bus_if.mem_addr}, {2'b10, fa});
    end
    bus_if.mem_rdata = {8'($urandom), op};
    bus_if.mem_ready = 1'b1;
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = DW'($urandom);
    if (ld || st) begin
      for (int i = 0; i <= dw; i++) begin
        if (ld) begin
          chk("load_req", {bus_if.mem_rd, bus_if.mem_wr, bus_if.mem_addr}, {2'b10, da});
        end else begin
          chk("store_req", {bus_if.mem_rd, bus_if.mem_wr, bus_if.mem_addr}, {2'b01, da});
          chk("store_data", bus_if.mem_wdata, op[0] ? m_dx : m_ax);
          if (bus_if.mem_wr === 1'b1) last_wr_cycles++;
        end
        if (i == dw) begin
          bus_if.mem_ready = 1'b1;
          if (ld) begin
            mval = dmem[m_ix];
            bus_if.mem_rdata = DW'(mval);
          end else begin
            dmem[m_ix] = int'(bus_if.mem_wdata);
          end
        end
        @(negedge clk);
      end
      bus_if.mem_ready = 1'b0;
      bus_if.mem_rdata = DW'($urandom);
    end
    chk("exec_illegal", illegal, is_rsv(op));
    chk("exec_idle", {bus_if.mem_rd, bus_if.mem_wr, halted}, 3'b000);
    model_exec(op, mval);
    @(negedge clk);
    check_state(hlt);
    chk("post_illegal", illegal, 1'b0);
    chk("post_halted", halted, hlt);
  endtask

  function automatic logic [7:0] rand_op();
    logic [7:0] op;
    int k;
    op = 8'($urandom);
    k  = $urandom_range(0, 11);
    case (k)
      0:       op = 8'h04 | {7'd0, op[0]};
      1, 2:    op[7:3] = 5'b00001;
      3, 4:    op[7:3] = 5'b00010;
      5:       op[7:3] = 5'b00011;
      6:       op[7:5] = 3'b001;
      7:       op[7:5] = 3'b011;
      8, 9:    op[7:6] = 2'b10;
      default: begin
        case (op[1:0])
          2'd0:    op = 8'h02 | {7'd0, op[2]};
          2'd1:    op[7:5] = 3'b010;
          default: op[7:6] = 2'b11;
        endcase
      end
    endcase
    return op;
  endfunction

  initial begin
    int save_ip, diff, guard;
    logic [7:0] jop;
    for (int i = 0; i < 32; i++) dmem[i] = $urandom_range(0, MOD - 1);

    do_reset();
    chk("rst_req", {bus_if.mem_rd, bus_if.mem_wr, halted, illegal}, 4'b1000);
    chk("rst_addr", bus_if.mem_addr, 0);
    chk("rst_wdata", bus_if.mem_wdata, 0);
    check_state(1'b0);

    // Immediate load, nibble shift-in, ADC with carry in
    exec_one(8'h8A, 0, 0);
    exec_one(8'hB4, 1, 0);
    exec_one(8'h83, 0, 0);
    exec_one(8'h05, 0, 0);
    exec_one(8'h08, 2, 0);
    chk("a_ax", dut.r_ax, 32'h5C);
    chk("a_flags", {dut.r_zf, dut.r_nf, dut.r_cf, dut.r_vf}, 4'b0000);

    // Reset while a fetch is stalled
    bus_if.mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("midrst_req", {bus_if.mem_rd, bus_if.mem_wr, halted, illegal}, 4'b1000);
    chk("midrst_addr", bus_if.mem_addr, 0);
    check_state(1'b0);

    // Signed overflow at the 16-bit boundary
    exec_one(8'h8E, 0, 0);
    repeat (3) exec_one(8'hBE, 0, 0);
    exec_one(8'h83, 0, 0);
    exec_one(8'h04, 0, 0);
    exec_one(8'h08, 0, 0);
    chk("b_ax", dut.r_ax, 32'h8000);
    chk("b_flags", {dut.r_zf, dut.r_nf, dut.r_cf, dut.r_vf}, 4'b0101);

    // Stalled store then reload through the index register
    exec_one(8'h23, 0, 0);
    exec_one(8'h88, 0, 0);
    exec_one(8'hA4, 0, 0);
    exec_one(8'h14, 0, 3);
    chk("c_wr_cycles", last_wr_cycles, 4);
    chk("c_mem3", dmem[3], 32'h42);
    exec_one(8'h13, 0, 1);
    chk("c_dx", dut.r_dx, 32'h42);

    // Zero flag skip, wrapping jump, self-loop
    exec_one(8'h11, 0, 0);
    exec_one(8'h0E, 0, 0);
    chk("d_zf", dut.r_zf, 1'b1);
    save_ip = m_ip;
    exec_one(8'h1A, 0, 0);
    chk("d_skip_ip", dut.r_ip, (save_ip + 2) % 256);
    guard = 0;
    while (m_ip != 254 && guard < 40) begin
      diff = (254 - m_ip + 256) % 256;
      if (diff <= 15)       jop = 8'h60 | 8'(diff);
      else if (diff >= 240) jop = 8'h60 | 8'((diff - 256) & 31);
      else                  jop = 8'h70;
      exec_one(jop, 0, 0);
      guard++;
    end
    chk("d_ip_fe", dut.r_ip, 8'hFE);
    exec_one(8'h63, 0, 0);
    chk("d_ip_wrap", dut.r_ip, 8'h01);
    exec_one(8'h60, 1, 0);
    chk("d_ip_self", dut.r_ip, 8'h01);

    // Reserved opcode, then HALT is absorbing
    exec_one(8'hC7, 0, 0);
    chk("e_ip", dut.r_ip, 8'h02);
    exec_one(8'h01, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("halt_quiet", {bus_if.mem_rd, bus_if.mem_wr, halted}, 3'b001);
    end

    // Random programs against the model
    do_reset();
    for (int i = 0; i < 400; i++)
      exec_one(rand_op(), $urandom_range(0, 2), $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
